gf180mcu_fd_sc_mcu7t5v0__cellbist2: RTL and testbench
=====================================================

GF180MCU_FD_SC_MCU7T5V0__CELLBIST2 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__cellbist2

Interface
REQ-001 SHALL have parameter TRUTH, default 4'b1000, expected Z per vector index {A2,A1} (bit i = expected Z for index i; default = and2).
REQ-002 SHALL have parameter SETTLE, default 2, settle cycles per vector, legal range 1..15.
REQ-003 SHALL have parameter ROUNDS, default 1, full 4-vector passes per run, legal range 1..15.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port START  input  1  run request, sampled only in IDLE.
REQ-007 SHALL have port Z  input  1  output of the cell under test.
REQ-008 SHALL have ports A1 and A2, each output 1, stimulus to the cell under test.
REQ-009 SHALL have port BUSY  output  1  high from run accept until DONE.
REQ-010 SHALL have port DONE  output  1  one-cycle end-of-run pulse.
REQ-011 SHALL have port PASS  output  1  high when the last run had zero mismatches; held until next accept.
REQ-012 SHALL have port ERR_CNT  output  3  mismatch count, saturates at 7.
REQ-013 SHALL have port FAIL_IDX  output  2  index of the first mismatch in the run, 0 if none.
REQ-014 SHALL have a single clock CLK and an asynchronous active-low reset RN.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, FIN.
REQ-016 IDLE: START=1 at an edge SHALL move to DRIVE, clear ERR_CNT/FAIL_IDX/PASS, and set index=0, round=0.
REQ-017 DRIVE (1 cycle): {A2,A1} SHALL equal the index; next state SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE cycles with stimulus held, then go to SAMPLE.
REQ-019 SAMPLE (1 cycle) SHALL compare Z against TRUTH[index]; on mismatch increment ERR_CNT (saturating) and, if first, load FAIL_IDX.
REQ-020 After SAMPLE, the index SHALL increment (mod 4); wrap from 3 increments round; round==ROUNDS-1 with index 3 SHALL go to FIN, otherwise DRIVE.
REQ-021 Each vector SHALL take SETTLE+2 cycles; DONE SHALL assert exactly 4*ROUNDS*(SETTLE+2) cycles after the accepting edge (16 with defaults).
REQ-022 FIN (1 cycle): DONE=1, PASS=(ERR_CNT==0), BUSY=0 next cycle, return to IDLE.
REQ-023 START while BUSY SHALL be ignored; START high in the FIN cycle SHALL be ignored; START high in the following IDLE cycle SHALL be accepted.
REQ-024 A1/A2 SHALL be 0 in IDLE and FIN.

Reset
REQ-025 RN low SHALL immediately force IDLE, A1=A2=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_IDX=0, SIG=0.
REQ-026 Reset mid-run SHALL abort with no DONE pulse; the first START after release SHALL begin a clean run.

Configuration
REQ-027 With GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN defined, SHALL add output SIG[7:0]: cleared on accept, updated each SAMPLE as next=(SIG<<1) ^ (SIG[7] ? 8'h71 : 0) ^ {7'b0,Z}, held otherwise.
REQ-028 Without the macro, SIG port and MISR logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package gf180mcu_fd_sc_mcu7t5v0__cellbist_pkg SHALL hold the FSM state enum, the MISR polynomial constant 8'h71, and the ERR_CNT saturation value.
REQ-030 The MISR SHALL be sub-module gf180mcu_fd_sc_mcu7t5v0__cellbist_misr, instantiated only under the macro.

Verification
REQ-031 Defaults, ideal and2 model on Z, START pulse -> DONE 16 cycles later, PASS=1, ERR_CNT=0, SIG=8'h01.
REQ-032 Z stuck at 0 -> PASS=0, ERR_CNT=1, FAIL_IDX=3.
REQ-033 Z stuck at 1, ROUNDS=3 -> ERR_CNT saturates at 7 (9 mismatches), FAIL_IDX=0, DONE 48 cycles after accept.
REQ-034 START re-asserted during a run and in the FIN cycle -> ignored; START in the next IDLE cycle -> new run, counters cleared.
REQ-035 RN pulled low during SETTLE of index 2 -> all outputs 0 immediately, no DONE; a subsequent run passes.
REQ-036 SETTLE=1 -> A1/A2 sequence 00,01,10,11 with 3 cycles per vector; DONE 12 cycles after accept.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cellbist_pkg.sv
// Shared types and constants for the two-input cell BIST sequencer.
package gf180mcu_fd_sc_mcu7t5v0__cellbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_e;

  localparam logic [7:0] MISR_POLY   = 8'h71;
  localparam logic [2:0] ERR_CNT_SAT = 3'd7;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cellbist2_if.sv
// Stimulus/response bundle between the BIST sequencer and the cell under test.
// SIG exists only with GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN defined.
interface gf180mcu_fd_sc_mcu7t5v0__cellbist2_if;
  logic       start;
  logic       z;
  logic       a1;
  logic       a2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_idx;
`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
  logic [7:0] sig;

  modport master (output start, z, input a1, a2, busy, done, pass, err_cnt, fail_idx, sig);
  modport slave  (input start, z, output a1, a2, busy, done, pass, err_cnt, fail_idx, sig);
`else
  modport master (output start, z, input a1, a2, busy, done, pass, err_cnt, fail_idx);
  modport slave  (input start, z, output a1, a2, busy, done, pass, err_cnt, fail_idx);
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cellbist2_core.sv
// BIST sequencer: walks {A2,A1} through 0..3 for ROUNDS passes, compares Z to TRUTH.
// Instantiates the MISR when GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0__cellbist2_core
  import gf180mcu_fd_sc_mcu7t5v0__cellbist_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ROUNDS = 1
) (
  input logic clk,
  input logic rst_n,
  gf180mcu_fd_sc_mcu7t5v0__cellbist2_if.slave bus
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] ROUND_LAST  = 4'(ROUNDS - 1);

  state_e     state_q;
  logic [1:0] idx_q, a_q, fidx_q;
  logic [3:0] round_q, cnt_q;
  logic [2:0] err_q;
  logic       busy_q, done_q, pass_q;
  logic       mismatch, last_vec;

  assign mismatch = (bus.z != TRUTH[idx_q]);
  assign last_vec = (idx_q == 2'd3) && (round_q == ROUND_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fidx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          state_q <= ST_DRIVE;
          idx_q   <= '0;
          round_q <= '0;
          a_q     <= '0;
          busy_q  <= 1'b1;
          pass_q  <= 1'b0;
          err_q   <= '0;
          fidx_q  <= '0;
        end
        ST_DRIVE: begin
          state_q <= ST_SETTLE;
          cnt_q   <= SETTLE_LAST;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_SAMPLE;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (err_q != ERR_CNT_SAT) err_q  <= err_q + 3'd1;
            if (err_q == '0)          fidx_q <= idx_q;
          end
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) round_q <= round_q + 4'd1;
          // PASS must reflect this final sample too, so it uses the pre-update count.
          if (last_vec) begin
            state_q <= ST_FIN;
            a_q     <= '0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !mismatch;
          end else begin
            state_q <= ST_DRIVE;
            a_q     <= idx_q + 2'd1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.a1       = a_q[0];
  assign bus.a2       = a_q[1];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_idx = fidx_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
  gf180mcu_fd_sc_mcu7t5v0__cellbist_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q == ST_IDLE) && bus.start),
    .en_i  (state_q == ST_SAMPLE),
    .z_i   (bus.z),
    .sig_o (bus.sig)
  );
`endif
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cellbist_misr.sv
// 8-bit signature register compacting the sampled Z stream of one run.
module gf180mcu_fd_sc_mcu7t5v0__cellbist_misr
  import gf180mcu_fd_sc_mcu7t5v0__cellbist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       z_i,
  output logic [7:0] sig_o
);
  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? MISR_POLY : 8'h00) ^ {7'b0, z_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cellbist2.sv
// Two-input cell BIST top with cell-library port names.
// Optional SIG output with GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN defined.
module gf180mcu_fd_sc_mcu7t5v0__cellbist2 #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ROUNDS = 1
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       Z,
  output logic       A1,
  output logic       A2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [2:0] ERR_CNT,
  output logic [1:0] FAIL_IDX
`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
  ,
  output logic [7:0] SIG
`endif
);
  gf180mcu_fd_sc_mcu7t5v0__cellbist2_if bus ();

  assign bus.start = START;
  assign bus.z     = Z;
  assign A1        = bus.a1;
  assign A2        = bus.a2;
  assign BUSY      = bus.busy;
  assign DONE      = bus.done;
  assign PASS      = bus.pass;
  assign ERR_CNT   = bus.err_cnt;
  assign FAIL_IDX  = bus.fail_idx;
`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
  assign SIG       = bus.sig;
`endif

  gf180mcu_fd_sc_mcu7t5v0__cellbist2_core #(
    .TRUTH  (TRUTH),
    .SETTLE (SETTLE),
    .ROUNDS (ROUNDS)
  ) u_core (
    .clk   (CLK),
    .rst_n (RN),
    .bus   (bus.slave)
  );
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__cellbist2.sv
// Bench for the two-input cell BIST: three instances (defaults, ROUNDS=3, SETTLE=1)
// each driving an and2 model whose per-vector output can be inverted by a fault mask.
module tb_gf180mcu_fd_sc_mcu7t5v0__cellbist2;
  localparam logic [3:0]  TRUTH_TB = 4'b1000;
  localparam int unsigned SET_P [3] = '{2, 2, 1};
  localparam int unsigned RND_P [3] = '{1, 3, 1};

  logic       clk = 1'b0;
  logic       rn  = 1'b0;
  logic       start_s [3];
  logic [3:0] flip_s  [3];
  logic [1:0] a_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       pass_s  [3];
  logic [2:0] err_s   [3];
  logic [1:0] fidx_s  [3];
  logic [7:0] sig_s   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf180mcu_fd_sc_mcu7t5v0__cellbist2_if bus ();

    assign bus.start = start_s[g];
    assign bus.z     = (bus.a1 & bus.a2) ^ flip_s[g][{bus.a2, bus.a1}];
    assign a_s[g]    = {bus.a2, bus.a1};
    assign busy_s[g] = bus.busy;
    assign done_s[g] = bus.done;
    assign pass_s[g] = bus.pass;
    assign err_s[g]  = bus.err_cnt;
    assign fidx_s[g] = bus.fail_idx;
`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
    assign sig_s[g]  = bus.sig;
`else
    assign sig_s[g]  = 8'h00;
`endif

    gf180mcu_fd_sc_mcu7t5v0__cellbist2 #(
      .TRUTH  (TRUTH_TB),
      .SETTLE (SET_P[g]),
      .ROUNDS (RND_P[g])
    ) dut (
      .CLK      (clk),
      .RN       (rn),
      .START    (bus.start),
      .Z        (bus.z),
      .A1       (bus.a1),
      .A2       (bus.a2),
      .BUSY     (bus.busy),
      .DONE     (bus.done),
      .PASS     (bus.pass),
      .ERR_CNT  (bus.err_cnt),
      .FAIL_IDX (bus.fail_idx)
`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
      ,
      .SIG      (bus.sig)
`endif
    );
  end

  // Reference: evaluate every applied vector of a run from the rules alone.
  function automatic void ref_run(input int unsigned rounds, input logic [3:0] flip,
                                  output logic [2:0] e, output logic [1:0] fi,
                                  output logic p, output logic [7:0] s);
    int unsigned cnt;
    logic        zb;
    cnt = 0;
    fi  = 2'd0;
    s   = 8'h00;
    for (int unsigned r = 0; r < rounds; r++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        zb = ((i == 3) ? 1'b1 : 1'b0) ^ flip[i];
        if (zb != TRUTH_TB[i]) begin
          if (cnt == 0) fi = 2'(i);
          cnt++;
        end
        s = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00) ^ {7'b0, zb};
      end
    end
    e = (cnt > 7) ? 3'd7 : 3'(cnt);
    p = (cnt == 0);
  endfunction

  task automatic run_one(input int d, input logic [3:0] flip, input string tag);
    int unsigned s, nexp, n, bad;
    logic [2:0]  e;
    logic [1:0]  fi;
    logic        p;
    logic [7:0]  sg;
    s    = SET_P[d];
    nexp = 4 * RND_P[d] * (s + 2);
    bad  = 0;
    ref_run(RND_P[d], flip, e, fi, p, sg);
    flip_s[d] = flip;
    @(negedge clk) start_s[d] = 1'b1;
    @(posedge clk); #1 start_s[d] = 1'b0;
    if (busy_s[d] !== 1'b1 || a_s[d] !== 2'd0) bad++;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (done_s[d] === 1'b1) break;
      if (a_s[d] !== 2'((n / (s + 2)) % 4) || busy_s[d] !== 1'b1) bad++;
    end
    checks++; if (n !== nexp) begin failures++;
      $display("FAIL %s latency got=%0d exp=%0d", tag, n, nexp); end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL %s stim_seq bad_cycles=%0d exp=0", tag, bad); end
    checks++; if (err_s[d] !== e) begin failures++;
      $display("FAIL %s err_cnt got=%0d exp=%0d", tag, err_s[d], e); end
    checks++; if (fidx_s[d] !== fi) begin failures++;
      $display("FAIL %s fail_idx got=%0d exp=%0d", tag, fidx_s[d], fi); end
    checks++; if (pass_s[d] !== p) begin failures++;
      $display("FAIL %s pass got=%0b exp=%0b", tag, pass_s[d], p); end
    checks++; if ({busy_s[d], a_s[d]} !== 3'b100) begin failures++;
      $display("FAIL %s fin_busy_a got=%b exp=100", tag, {busy_s[d], a_s[d]}); end
`ifdef GF180MCU_FD_SC_MCU7T5V0__CELLBIST_MISR_EN
    checks++; if (sig_s[d] !== sg) begin failures++;
      $display("FAIL %s sig got=%h exp=%h", tag, sig_s[d], sg); end
`endif
    @(posedge clk); #1;
    checks++; if ({busy_s[d], done_s[d], pass_s[d]} !== {2'b00, p}) begin failures++;
      $display("FAIL %s after_fin busy_done_pass got=%b exp=%b", tag,
               {busy_s[d], done_s[d], pass_s[d]}, {2'b00, p}); end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      flip_s[d]  = 4'b0000;
    end
    rn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_s[d], busy_s[d], done_s[d], pass_s[d], err_s[d], fidx_s[d], sig_s[d]} !== 18'd0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got=%h exp=0", d,
                 {a_s[d], busy_s[d], done_s[d], pass_s[d], err_s[d], fidx_s[d], sig_s[d]});
      end
    end
    @(negedge clk) rn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ideal();      run_one(0, 4'b0000, "ideal_and2");   endtask
  task automatic test_stuck0();     run_one(0, 4'b1000, "stuck0");       endtask
  task automatic test_stuck1_r3();  run_one(1, 4'b0111, "stuck1_r3");    endtask
  task automatic test_settle1();    run_one(2, 4'b0000, "settle1");      endtask

  task automatic test_random();
    int          d;
    logic [3:0]  f;
    for (int k = 0; k < 8; k++) begin
      d = int'($urandom_range(0, 2));
      f = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_one(d, f, $sformatf("rand%0d_dut%0d_f%h", k, d, f));
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    flip_s[0] = 4'b0100;
    @(negedge clk) start_s[0] = 1'b1;
    @(posedge clk); #1;
    for (n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_s[0] === 1'b1) break;
    end
    checks++; if (n !== 16) begin failures++;
      $display("FAIL b2b_first_latency got=%0d exp=16", n); end
    checks++; if ({err_s[0], fidx_s[0]} !== {3'd1, 2'd2}) begin failures++;
      $display("FAIL b2b_first_err_fidx got=%0d/%0d exp=1/2", err_s[0], fidx_s[0]); end
    flip_s[0] = 4'b0000;
    @(posedge clk); #1;
    checks++; if ({busy_s[0], pass_s[0], fidx_s[0]} !== {1'b0, 1'b0, 2'd2}) begin failures++;
      $display("FAIL b2b_fin_start_ignored busy_pass_fidx got=%b exp=0010",
               {busy_s[0], pass_s[0], fidx_s[0]}); end
    @(posedge clk); #1 start_s[0] = 1'b0;
    checks++; if ({busy_s[0], err_s[0], fidx_s[0]} !== 6'b100000) begin failures++;
      $display("FAIL b2b_reaccept busy_err_fidx got=%b exp=100000",
               {busy_s[0], err_s[0], fidx_s[0]}); end
    for (n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_s[0] === 1'b1) break;
    end
    checks++; if (n !== 16 || pass_s[0] !== 1'b1 || err_s[0] !== 3'd0) begin failures++;
      $display("FAIL b2b_second_run lat_pass_err got=%0d/%0b/%0d exp=16/1/0",
               n, pass_s[0], err_s[0]); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    flip_s[0] = 4'b0001;
    @(negedge clk) start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if ({a_s[0], err_s[0], busy_s[0]} !== {2'd2, 3'd1, 1'b1}) begin failures++;
      $display("FAIL midrun_state a_err_busy got=%0d/%0d/%0b exp=2/1/1",
               a_s[0], err_s[0], busy_s[0]); end
    rn = 1'b0;
    #1;
    checks++;
    if ({a_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fidx_s[0], sig_s[0]} !== 18'd0) begin
      failures++;
      $display("FAIL midrun_reset_outputs got=%h exp=0",
               {a_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fidx_s[0], sig_s[0]});
    end
    @(negedge clk) rn = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL midrun_no_done got=activity exp=idle"); end
    run_one(0, 4'b0000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck0();
    test_stuck1_r3();
    test_settle1();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
